// File: rtl/level_meter.sv
// level_meter: LED bar level meter with peak-hold, peak decay and clip
// indicator, all refreshed once per display update tick.
module level_meter #(
  parameter int BUS_WIDTH     = 6,
  parameter int UPDATE_PERIOD = 512,
  parameter int HOLD_TICKS    = 16,
  parameter int DECAY         = 2,
  parameter int CLIP_TICKS    = 8
) (
  input  logic                 dclk,
  input  logic                 rst,
  input  logic [BUS_WIDTH-1:0] level,
  output logic [7:0]           bar,
  output logic [7:0]           peak_led,
  output logic                 clip,
  output logic                 tick
);

  localparam int CW = (UPDATE_PERIOD > 1) ? $clog2(UPDATE_PERIOD) : 1;
  localparam int S  = 1 << (BUS_WIDTH - 3);

  localparam logic [CW-1:0]        CNT_MAX = CW'(UPDATE_PERIOD - 1);
  localparam logic [BUS_WIDTH-1:0] FULL    = '1;
  localparam logic [BUS_WIDTH-1:0] DEC     = BUS_WIDTH'(DECAY);
  localparam logic [7:0]           HOLD    = 8'(HOLD_TICKS);
  localparam logic [7:0]           CLIPN   = 8'(CLIP_TICKS);

  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BUS_WIDTH-1:0] peak_q, peak_d;
  logic [7:0]           hold_q, hold_d;
  logic [7:0]           clipc_q, clipc_d;
  logic [7:0]           bar_q, bar_d;
  logic [7:0]           led_q, led_d;
  logic                 clip_q, clip_d;
  logic [BUS_WIDTH-1:0] pm1;

  assign tick     = (cnt_q == CNT_MAX);
  assign bar      = bar_q;
  assign peak_led = led_q;
  assign clip     = clip_q;

  // Free-running update counter; tick marks its terminal count.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (tick) begin
      cnt_d = '0;
    end
  end

  // Peak-hold/decay and clip-stretch state, advanced only on tick.
  always_comb begin
    peak_d  = peak_q;
    hold_d  = hold_q;
    clipc_d = clipc_q;
    if (tick) begin
      if (level >= peak_q) begin
        peak_d = level;
        hold_d = HOLD;
      end else if (hold_q != 8'h00) begin
        hold_d = hold_q - 8'h01;
      end else if (peak_q > DEC) begin
        peak_d = peak_q - DEC;
      end else begin
        peak_d = '0;
      end
      if (level == FULL) begin
        clipc_d = CLIPN;
      end else if (clipc_q != 8'h00) begin
        clipc_d = clipc_q - 8'h01;
      end
    end
  end

  // Display decode from the sampled level and the updated peak.
  always_comb begin
    bar_d  = bar_q;
    led_d  = led_q;
    clip_d = clip_q;
    pm1    = peak_d - BUS_WIDTH'(1);
    if (tick) begin
      for (int i = 0; i < 8; i++) begin
        bar_d[i] = int'(level) > (i * S);
      end
      if (peak_d == '0) begin
        led_d = 8'h00;
      end else begin
        led_d = 8'h01 << pm1[BUS_WIDTH-1:BUS_WIDTH-3];
      end
      clip_d = (clipc_d != 8'h00);
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge dclk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      peak_q  <= '0;
      hold_q  <= 8'h00;
      clipc_q <= 8'h00;
      bar_q   <= 8'h00;
      led_q   <= 8'h00;
      clip_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      peak_q  <= peak_d;
      hold_q  <= hold_d;
      clipc_q <= clipc_d;
      bar_q   <= bar_d;
      led_q   <= led_d;
      clip_q  <= clip_d;
    end
  end

endmodule

// File: tb/tb_level_meter.sv
// tb_level_meter: randomized bench for level_meter against an
// arithmetic reference model, plus directed checks of key scenarios.
module tb_level_meter;

  localparam int BW = 6;
  localparam int P  = 512;
  localparam int H  = 16;
  localparam int D  = 2;
  localparam int C  = 8;
  localparam int S  = 1 << (BW - 3);
  localparam int FS = (1 << BW) - 1;

  logic          dclk;
  logic          rst;
  logic [BW-1:0] level;
  logic [7:0]    bar;
  logic [7:0]    peak_led;
  logic          clip;
  logic          tick;

  int n_chk;
  int n_fail;

  int m_cnt;
  int m_peak;
  int m_hold;
  int m_clipc;
  int m_bar;
  int m_led;
  int m_clip;

  level_meter #(
    .BUS_WIDTH    (BW),
    .UPDATE_PERIOD(P),
    .HOLD_TICKS   (H),
    .DECAY        (D),
    .CLIP_TICKS   (C)
  ) dut (
    .dclk    (dclk),
    .rst     (rst),
    .level   (level),
    .bar     (bar),
    .peak_led(peak_led),
    .clip    (clip),
    .tick    (tick)
  );

  initial dclk = 1'b0;
  always #5 dclk = ~dclk;

  initial begin
    #1500000;
    $display("FAIL timeout: run did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got=%0d (0x%0h) exp=%0d (0x%0h) t=%0t",
               tag, got, got, exp, exp, $time);
    end
  endtask

  function automatic int seg_bar(input int lv);
    int n;
    n = (lv + S - 1) / S;
    if (n > 8) n = 8;
    return (1 << n) - 1;
  endfunction

  function automatic int led_of(input int pk);
    if (pk == 0) return 0;
    return 1 << ((pk - 1) / S);
  endfunction

  task automatic model_reset();
    m_cnt   = 0;
    m_peak  = 0;
    m_hold  = 0;
    m_clipc = 0;
    m_bar   = 0;
    m_led   = 0;
    m_clip  = 0;
  endtask

  task automatic model_tick(input int lv);
    if (lv >= m_peak) begin
      m_peak = lv;
      m_hold = H;
    end else if (m_hold > 0) begin
      m_hold = m_hold - 1;
    end else begin
      m_peak = (m_peak > D) ? m_peak - D : 0;
    end
    if (lv == FS) m_clipc = C;
    else if (m_clipc > 0) m_clipc = m_clipc - 1;
    m_bar  = seg_bar(lv);
    m_led  = led_of(m_peak);
    m_clip = (m_clipc != 0) ? 1 : 0;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input int lv);
    chk("tick", int'(tick), (m_cnt == P - 1) ? 1 : 0);
    chk("bar", int'(bar), m_bar);
    chk("peak_led", int'(peak_led), m_led);
    chk("clip", int'(clip), m_clip);
    level = lv[BW-1:0];
    @(posedge dclk);
    if (m_cnt == P - 1) begin
      model_tick(lv);
      m_cnt = 0;
    end else begin
      m_cnt++;
    end
    @(negedge dclk);
  endtask

  function automatic int rnd_lvl();
    return int'($urandom_range(0, FS));
  endfunction

  // Random levels between ticks, lv presented on the tick edge.
  task automatic tick_at(input int lv);
    int guard;
    guard = 0;
    while (m_cnt != P - 1 && guard < P + 4) begin
      step(rnd_lvl());
      guard++;
    end
    step(lv);
  endtask

  task automatic do_reset();
    #1;
    rst = 1'b1;
    #1;
    chk("rst_bar", int'(bar), 0);
    chk("rst_led", int'(peak_led), 0);
    chk("rst_clip", int'(clip), 0);
    chk("rst_tick", int'(tick), 0);
    @(negedge dclk);
    @(negedge dclk);
    chk("rst_hold_tick", int'(tick), 0);
    rst = 1'b0;
    model_reset();
  endtask

  // Counts edges up to and including the first tick edge.
  task automatic first_tick(input int lv);
    int n;
    n = 0;
    while (!tick && n < P + 64) begin
      step(lv);
      n++;
    end
    chk("first_tick_edge", n + 1, P);
    step(lv);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    level  = 6'd40;
    model_reset();
    repeat (3) @(negedge dclk);
    do_reset();

    first_tick(40);
    chk("l40_bar", int'(bar), 8'h1F);
    chk("l40_led", int'(peak_led), 8'h10);
    chk("l40_clip", int'(clip), 0);

    do_reset();
    for (int k = 0; k < 3; k++) begin
      tick_at(20);
      chk("l20_bar", int'(bar), 8'h07);
      chk("l20_led", int'(peak_led), 8'h04);
    end

    do_reset();
    tick_at(FS);
    chk("fs_bar", int'(bar), 8'hFF);
    chk("fs_led", int'(peak_led), 8'h80);
    chk("fs_clip", int'(clip), 1);
    for (int k = 1; k <= 49; k++) begin
      tick_at(0);
      chk("clip_stretch", int'(clip), (k <= 7) ? 1 : 0);
      if (k == 16) chk("hold_end_led", int'(peak_led), 8'h80);
      if (k == 47) chk("decay_1_led", int'(peak_led), 8'h01);
      if (k == 48) chk("decay_0_led", int'(peak_led), 8'h00);
      if (k == 49) chk("no_wrap_led", int'(peak_led), 8'h00);
    end

    do_reset();
    tick_at(54);
    for (int k = 0; k < 18; k++) tick_at(0);
    chk("pk50_led", int'(peak_led), 8'h40);
    tick_at(50);
    for (int k = 0; k < 16; k++) tick_at(0);
    chk("rearm_hold_led", int'(peak_led), 8'h40);
    tick_at(0);
    chk("rearm_decay_led", int'(peak_led), 8'h20);
    tick_at(55);
    chk("pk55_led", int'(peak_led), 8'h40);
    chk("pk55_bar", int'(bar), 8'h7F);

    for (int k = 0; k < 8; k++) begin
      tick_at(($urandom_range(0, 3) == 0) ? FS : rnd_lvl());
    end

    do_reset();
    tick_at(FS);
    for (int k = 0; k < 3; k++) tick_at(0);
    chk("mid_hold_clip", int'(clip), 1);
    chk("mid_hold_led", int'(peak_led), 8'h80);
    repeat (100) step(rnd_lvl());
    do_reset();
    first_tick(rnd_lvl());
    tick_at(rnd_lvl());

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/level_meter.md
LEVEL_METER -- requirements
Module: level_meter

Interface
REQ-001 Parameter BUS_WIDTH, default 6, sets the width of the level input and the peak register; the minimum value is 3.
REQ-002 Parameter UPDATE_PERIOD, default 512, sets the number of dclk cycles per display update tick; the legal range is 2..65536.
REQ-003 Parameter HOLD_TICKS, default 16, sets the number of ticks the peak is held before it decays; the legal range is 0..255.
REQ-004 Parameter DECAY, default 2, sets the amount subtracted from the peak per tick once the hold has expired; the legal range is 1..2^BUS_WIDTH-1.
REQ-005 Parameter CLIP_TICKS, default 8, sets the number of ticks the clip indicator stays asserted after a full-scale level; the legal range is 1..255.
REQ-006 dclk  in  1  is the single clock; all state changes on its rising edge.
REQ-007 rst  in  1  is the asynchronous, active-high reset.
REQ-008 level  in  BUS_WIDTH  is the unsigned peak level from the upstream max stage; it may change on any cycle.
REQ-009 bar  out  8  is the thermometer LED bar, with bit 0 as the lowest segment.
REQ-010 peak_led  out  8  is the one-hot peak-hold LED; it is all zeros when the peak is 0.
REQ-011 clip  out  1  is the clip indicator.
REQ-012 tick  out  1  is a single-cycle strobe that is high on the cycle in which the update occurs.

Function
REQ-013 The block SHALL contain a free-running update counter, cnt, that wraps from UPDATE_PERIOD-1 to 0; tick SHALL be high exactly when cnt equals UPDATE_PERIOD-1.
REQ-014 level SHALL be sampled only on the dclk edge where tick is high; the block SHALL ignore level at all other times.
REQ-015 bar, peak_led and clip SHALL be registered, update only on tick edges, and reflect the sampled level starting on the cycle after the tick.
REQ-016 With S = 2^(BUS_WIDTH-3), bar[i] SHALL be 1 if and only if sampled level > i*S, for i=0..7; level 0 gives bar=0x00 and level 2^BUS_WIDTH-1 gives bar=0xFF.
REQ-017 peak_led SHALL be 0x00 when the peak is 0; otherwise only bit (peak-1)/S SHALL be set.
REQ-018 Peak state SHALL consist of a peak register (BUS_WIDTH bits) and hold_cnt (8 bits); on each tick the first matching rule applies:
  - level >= peak: peak <= level, hold_cnt <= HOLD_TICKS (an equal level re-arms the hold).
  - hold_cnt != 0: hold_cnt <= hold_cnt-1, peak unchanged.
  - otherwise: peak <= peak-DECAY if peak > DECAY, else 0 (saturating, no wrap).
REQ-019 peak_led SHALL be derived from the peak value after the update rule of REQ-018 has been applied on that tick.
REQ-020 Clip state SHALL be an 8-bit clip_cnt updated on each tick:
  - level == all ones: clip_cnt <= CLIP_TICKS.
  - else if clip_cnt != 0: clip_cnt <= clip_cnt-1.
  - clip SHALL be registered as (new clip_cnt != 0).
REQ-021 When HOLD_TICKS=0, decay SHALL begin on the first tick after a load on which level < peak.
REQ-022 The counter SHALL continue running between ticks; no input other than rst SHALL stall, restart or alter it.

Reset
REQ-023 While rst is high, cnt, peak, hold_cnt and clip_cnt SHALL be 0, and bar=0x00, peak_led=0x00, clip=0, tick=0.
REQ-024 An assertion of rst mid-hold or mid-decay SHALL clear the state immediately, without waiting for a clock edge.
REQ-025 After rst deasserts, the first tick SHALL occur on the UPDATE_PERIOD-th rising edge of dclk.

Verification (BUS_WIDTH=6, UPDATE_PERIOD=512, HOLD_TICKS=16, DECAY=2, CLIP_TICKS=8)
REQ-026 Release rst with level=40 -> all outputs 0 for 511 cycles; tick high on cycle 512; then bar=0x1F and peak_led=0x10.
REQ-027 Hold level=20 -> bar=0x07 and peak_led=0x04, stable across ticks; toggling level between ticks has no effect.
REQ-028 Apply level=63 for one tick, then 0 -> the following are all required:
  - clip=1 from the load tick through 7 further ticks, then 0 on the 8th subsequent tick.
  - peak=63 (peak_led=0x80) holds for 16 ticks; on the 17th it becomes 61; it reaches 0 after 32 decay ticks (…3, 1, 0) and never wraps.
REQ-029 With peak at 50 mid-decay, apply level=50 -> hold re-arms at 16 and peak stays 50; level=55 then gives peak=55, with peak_led moving to 0x40.
REQ-030 Assert rst asynchronously mid-hold with peak=63 and clip=1 -> all outputs read 0 before the next dclk edge; after release, the tick period restarts from 0.
